hdrgen_stage_p: RTL and testbench
=================================

HDRGEN_STAGE_P -- requirements
Module: hdrgen_stage_p

Interface
REQ-001 Parameter CH_W, default 4, channel-index width (2**CH_W channels).
REQ-002 Parameter UC_AW, default 9, microcode offset width per channel.
REQ-003 Parameter UC_DW, default 9, microcode word width.
REQ-004 Parameter REG_W, default 16, per-channel register and payload width.
REQ-005 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: request beat present.
REQ-008 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-009 Port in_chan, input, CH_W: channel (VLAN slot) index.
REQ-010 Port in_idx, input, UC_AW: microcode offset within the channel.
REQ-011 Port in_data, input, REG_W: payload, passed through.
REQ-012 Port out_valid, output, 1: result beat present.
REQ-013 Port out_ready, input, 1: downstream accepts the result.
REQ-014 Port out_uc, output, UC_DW: microcode word at {chan, idx}.
REQ-015 Port out_data, output, REG_W: in_data, delayed.
REQ-016 Port out_l3len, output, REG_W: l3_hdr_length register of chan.
REQ-017 Port out_csum, output, REG_W: precalculated IPv4 inverted checksum of chan.
REQ-018 Port mgmt_we, input, 1: management write strobe.
REQ-019 Port mgmt_sel, input, 2: target; 0 microcode, 1 l3len, 2 csum, 3 channel-enable mask.
REQ-020 Port mgmt_addr, input, CH_W+UC_AW: {chan, idx} for sel 0; chan in low CH_W bits for sel 1/2.
REQ-021 Port mgmt_wdata, input, REG_W: write data (low UC_DW bits for sel 0; low 2**CH_W bits for sel 3).
REQ-022 Port drop_cnt, output, 16: count of beats dropped on disabled channels.

Function
REQ-023 Beat transfers when in_valid and in_ready are high at the same rising edge; output transfers when out_valid and out_ready are high.
REQ-024 Latency from input transfer to out_valid is exactly 2 cycles when the output is idle and out_ready is high.
REQ-025 Throughput is one beat per cycle while out_ready stays high; beats are never lost, duplicated or reordered.
REQ-026 While out_valid is high and out_ready is low, all out_* values are held stable.
REQ-027 in_ready is driven from registers only, with no combinational path from out_ready or in_valid.
REQ-028 Internal output skid buffer of 2 entries; in_ready is low when buffered plus in-flight beats equal 2, otherwise high.
REQ-029 in_ready is low in every cycle in which mgmt_we is high, so management writes always win over lookups.
REQ-030 A beat accepted before a management write to the same entry returns the old contents; a beat accepted after it returns the new contents.
REQ-031 Mask write (sel 3) updates the enable mask the following cycle and also clears drop_cnt to 0.
REQ-032 A beat whose in_chan bit in the mask is 0 is accepted and discarded; it produces no output beat.
REQ-033 Each discarded beat increments drop_cnt by 1; drop_cnt saturates at 16'hFFFF.
REQ-034 If a discard and a mask write coincide, the clear takes priority and drop_cnt becomes 0.
REQ-035 Unused high bits of mgmt_addr and mgmt_wdata are ignored; out-of-range mask bits do not exist.

Reset
REQ-036 On rst: out_valid 0, in_ready 0 during reset and 1 on the first cycle after it, out_uc/out_data/out_l3len/out_csum 0, drop_cnt 0, mask all ones, skid buffer and in-flight beats flushed.
REQ-037 RAM and register-file contents are not cleared by rst.
REQ-038 rst asserted mid-stream discards all pending beats; no out_valid is asserted for them afterwards.

Structure
REQ-039 Shared package hdrgen_pkg holds parameter defaults and the mgmt_sel encoding constants.
REQ-040 Sub-module hdrgen_sdp_ram is a simple dual-port synchronous-read RAM, parametrised in width and depth, instantiated for microcode, l3len and csum.

Verification
REQ-041 Program uc[{c,i}]={c,i[3:0]}, l3len[c]={4{c}}, csum[c]={F,c,c,F} for all 16 channels; stream 256 beats with out_ready=1 -> each result arrives 2 cycles after acceptance with matching values, one per cycle.
REQ-042 Random out_ready at 50% over 1000 beats -> in-order, lossless output; values held while stalled; in_ready never high with 2 beats buffered or in flight.
REQ-043 mgmt_we asserted during a stream -> in_ready low that cycle; lookup of the same entry after the write returns the new value.
REQ-044 Mask 16'hFFFE, then 10 beats on channel 0 and 5 on channel 1 -> 5 outputs, drop_cnt=10; mask write that coincides with a discard -> drop_cnt=0.
REQ-045 Force drop_cnt toward saturation with 70000 discards -> drop_cnt holds 16'hFFFF.
REQ-046 rst for one cycle with 2 beats pending -> out_valid 0 the next cycle, no stale outputs afterwards, RAM contents intact.

Source files
------------

// File: rtl/hdrgen_pkg.sv
// Shared definitions for the header-generation stage: parameter defaults,
// management target encoding and a saturating counter helper.
package hdrgen_pkg;

  localparam int unsigned CH_W_DEF  = 4;
  localparam int unsigned UC_AW_DEF = 9;
  localparam int unsigned UC_DW_DEF = 9;
  localparam int unsigned REG_W_DEF = 16;

  // Management write targets
  typedef enum logic [1:0] {
    SEL_UC    = 2'd0,
    SEL_L3LEN = 2'd1,
    SEL_CSUM  = 2'd2,
    SEL_MASK  = 2'd3
  } mgmt_sel_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hdrgen_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports:
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read enable/address; rdata is valid the cycle after re
//   rdata        - registered read data (old contents on same-edge write)
// Contents are not reset.
module hdrgen_sdp_ram #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdrgen_stage_p.sv
// Header-generation lookup stage. Each accepted beat looks up the microcode
// word at {chan, idx} plus the channel's l3 length and precomputed IPv4
// checksum, and emits them alongside the passed-through payload.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_valid/in_ready       - request handshake (in_chan, in_idx, in_data)
//   out_valid/out_ready     - result handshake (out_uc, out_data,
//                             out_l3len, out_csum)
//   mgmt_we/sel/addr/wdata  - management writes (microcode, l3len, csum,
//                             channel-enable mask)
//   drop_cnt                - saturating count of beats discarded on
//                             disabled channels
// Pipeline: accept edge reads the RAMs (stage 1), next edge loads the output
// register or, if it is occupied, a 2-entry skid buffer behind it.
module hdrgen_stage_p
  import hdrgen_pkg::*;
#(
  parameter int unsigned CH_W  = CH_W_DEF,
  parameter int unsigned UC_AW = UC_AW_DEF,
  parameter int unsigned UC_DW = UC_DW_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH_W-1:0]       in_chan,
  input  logic [UC_AW-1:0]      in_idx,
  input  logic [REG_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [UC_DW-1:0]      out_uc,
  output logic [REG_W-1:0]      out_data,
  output logic [REG_W-1:0]      out_l3len,
  output logic [REG_W-1:0]      out_csum,
  input  logic                  mgmt_we,
  input  logic [1:0]            mgmt_sel,
  input  logic [CH_W+UC_AW-1:0] mgmt_addr,
  input  logic [REG_W-1:0]      mgmt_wdata,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned NCH = 1 << CH_W;

  typedef struct packed {
    logic [UC_DW-1:0] uc;
    logic [REG_W-1:0] data;
    logic [REG_W-1:0] l3len;
    logic [REG_W-1:0] csum;
  } beat_t;

  mgmt_sel_e sel;
  logic      accept;
  logic      keep_now;
  logic      uc_we, l3_we, cs_we, mask_we;

  logic [UC_DW-1:0] uc_rd;
  logic [REG_W-1:0] l3_rd, cs_rd;

  // Stage 1: beat in flight while the RAM read completes
  logic             s1_v, s1_keep;
  logic [REG_W-1:0] s1_data;

  // Output register plus skid buffer
  logic       ov_q, ov_n;
  beat_t      out_q, out_n;
  beat_t      skid_q [2];
  beat_t      skid_n [2];
  logic [1:0] sc_q, sc_n;
  logic       rdy_q, rdy_n;

  logic [NCH-1:0] mask_q;
  logic [15:0]    drop_q;

  logic  pop, inc;
  beat_t inc_beat;

  assign sel     = mgmt_sel_e'(mgmt_sel);
  assign uc_we   = mgmt_we && (sel == SEL_UC);
  assign l3_we   = mgmt_we && (sel == SEL_L3LEN);
  assign cs_we   = mgmt_we && (sel == SEL_CSUM);
  assign mask_we = mgmt_we && (sel == SEL_MASK);

  // rdy_q only tracks occupancy; rst and mgmt_we gate it so management
  // writes never share a cycle with a lookup.
  assign in_ready = rdy_q && !rst && !mgmt_we;
  assign accept   = in_valid && in_ready;
  assign keep_now = mask_q[in_chan];

  hdrgen_sdp_ram #(.W(UC_DW), .AW(CH_W + UC_AW)) u_uc_ram (
    .clk   (clk),
    .we    (uc_we),
    .waddr (mgmt_addr),
    .wdata (mgmt_wdata[UC_DW-1:0]),
    .re    (accept),
    .raddr ({in_chan, in_idx}),
    .rdata (uc_rd)
  );

  hdrgen_sdp_ram #(.W(REG_W), .AW(CH_W)) u_l3len_ram (
    .clk   (clk),
    .we    (l3_we),
    .waddr (mgmt_addr[CH_W-1:0]),
    .wdata (mgmt_wdata),
    .re    (accept),
    .raddr (in_chan),
    .rdata (l3_rd)
  );

  hdrgen_sdp_ram #(.W(REG_W), .AW(CH_W)) u_csum_ram (
    .clk   (clk),
    .we    (cs_we),
    .waddr (mgmt_addr[CH_W-1:0]),
    .wdata (mgmt_wdata),
    .re    (accept),
    .raddr (in_chan),
    .rdata (cs_rd)
  );

  // Ordering is output register, then skid[0], skid[1], then the stage-1
  // beat; the whole list shifts by one when the output register empties.
  always_comb begin
    pop      = ov_q && out_ready;
    inc      = s1_v && s1_keep;
    inc_beat.uc    = uc_rd;
    inc_beat.data  = s1_data;
    inc_beat.l3len = l3_rd;
    inc_beat.csum  = cs_rd;
    ov_n   = ov_q;
    out_n  = out_q;
    skid_n = skid_q;
    sc_n   = sc_q;
    if (ov_q && !pop) begin
      // Flow control keeps sc_q <= 1 whenever a beat can arrive here
      if (inc) begin
        skid_n[sc_q[0]] = inc_beat;
        sc_n            = sc_q + 2'd1;
      end
    end else if (sc_q != 2'd0) begin
      ov_n      = 1'b1;
      out_n     = skid_q[0];
      skid_n[0] = skid_q[1];
      if (inc) skid_n[sc_q[1]] = inc_beat;
      sc_n = sc_q - 2'd1 + {1'b0, inc};
    end else begin
      ov_n = inc;
      if (inc) out_n = inc_beat;
    end
    // Room must remain for the stage-1 beat and one more acceptance even
    // if the output stalls from now on.
    rdy_n = ({1'b0, sc_n} + {2'b00, accept && keep_now}) < 3'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      ov_q   <= 1'b0;
      out_q  <= '0;
      sc_q   <= 2'd0;
      rdy_q  <= 1'b1;
      mask_q <= '1;
      drop_q <= '0;
    end else begin
      s1_v  <= accept;
      ov_q  <= ov_n;
      out_q <= out_n;
      sc_q  <= sc_n;
      rdy_q <= rdy_n;
      if (mask_we) mask_q <= mgmt_wdata[NCH-1:0];
      // Discards are counted as they leave stage 1; a mask write on the
      // same edge clears the counter and wins.
      if (mask_we)               drop_q <= '0;
      else if (s1_v && !s1_keep) drop_q <= sat_inc16(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    s1_keep <= keep_now;
    s1_data <= in_data;
    skid_q  <= skid_n;
  end

  assign out_valid = ov_q;
  assign out_uc    = out_q.uc;
  assign out_data  = out_q.data;
  assign out_l3len = out_q.l3len;
  assign out_csum  = out_q.csum;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_hdrgen_stage_p.sv
module tb_hdrgen_stage_p;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_chan;
  logic [8:0]  in_idx;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_uc;
  logic [15:0] out_data;
  logic [15:0] out_l3len;
  logic [15:0] out_csum;
  logic        mgmt_we;
  logic [1:0]  mgmt_sel;
  logic [12:0] mgmt_addr;
  logic [15:0] mgmt_wdata;
  logic [15:0] drop_cnt;

  hdrgen_stage_p #(.CH_W(4), .UC_AW(9), .UC_DW(9), .REG_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chan    (in_chan),
    .in_idx     (in_idx),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_uc     (out_uc),
    .out_data   (out_data),
    .out_l3len  (out_l3len),
    .out_csum   (out_csum),
    .mgmt_we    (mgmt_we),
    .mgmt_sel   (mgmt_sel),
    .mgmt_addr  (mgmt_addr),
    .mgmt_wdata (mgmt_wdata),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [56:0] val;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  uc_m [8192];
  logic [15:0] l3_m [16];
  logic [15:0] cs_m [16];
  logic [15:0] mask_m;
  int unsigned drop_m;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   n_acc    = 0;
  logic last_acc = 1'b0;
  logic hold_pend = 1'b0;
  logic [56:0] held;
  logic prev_rst = 1'b0;
  logic lat_chk  = 1'b0;
  logic tput_chk = 1'b0;
  logic or_rand  = 1'b0;
  logic mg_rand  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a falling edge with inputs set for the next rising edge.
  task automatic tick();
    logic [56:0] cur;
    exp_t e;
    #1;
    cyc++;
    cur = {out_uc, out_data, out_l3len, out_csum};
    if (hold_pend) begin
      check_eq("hold_valid", out_valid, 1);
      if (out_valid) check_eq("hold_data", cur, held);
    end
    if (exp_q.size() == 0) check_eq("idle_valid", out_valid, 0);
    if (mgmt_we) check_eq("mgmt_rdy", in_ready, 0);
    if (rst) check_eq("rst_rdy", in_ready, 0);
    else if (prev_rst && !mgmt_we) check_eq("post_rst_rdy", in_ready, 1);
    if (tput_chk && in_valid && !mgmt_we) check_eq("tput_rdy", in_ready, 1);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      n_out++;
      e = exp_q.pop_front();
      check_eq("out_beat", cur, e.val);
      if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 2);
    end
    hold_pend = out_valid && !out_ready;
    held      = cur;
    last_acc  = in_valid && in_ready && !rst;
    if (last_acc) begin
      n_acc++;
      if (mask_m[in_chan]) begin
        e.val = {uc_m[{in_chan, in_idx}], in_data, l3_m[in_chan], cs_m[in_chan]};
        e.cyc = cyc;
        exp_q.push_back(e);
      end else if (drop_m < 65535) begin
        drop_m++;
      end
    end
    if (mgmt_we && !rst) begin
      case (mgmt_sel)
        2'd0: uc_m[mgmt_addr] = mgmt_wdata[8:0];
        2'd1: l3_m[mgmt_addr[3:0]] = mgmt_wdata;
        2'd2: cs_m[mgmt_addr[3:0]] = mgmt_wdata;
        default: begin mask_m = mgmt_wdata; drop_m = 0; end
      endcase
    end
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
      mask_m    = 16'hFFFF;
      drop_m    = 0;
    end
    prev_rst = rst;
    @(negedge clk);
  endtask

  task automatic randomize_side();
    out_ready = or_rand ? 1'($urandom_range(1)) : 1'b1;
    mgmt_we   = 1'b0;
    if (mg_rand && $urandom_range(9) == 0) begin
      mgmt_we    = 1'b1;
      mgmt_sel   = 2'($urandom_range(2));
      mgmt_wdata = 16'($urandom);
      if (mgmt_sel == 2'd0) mgmt_addr = {4'($urandom), 9'($urandom_range(31))};
      else                  mgmt_addr = 13'($urandom);
    end
  endtask

  task automatic send(input logic [3:0] ch, input logic [8:0] idx, input logic [15:0] d);
    int unsigned k = 0;
    in_valid = 1'b1;
    in_chan  = ch;
    in_idx   = idx;
    in_data  = d;
    do begin
      randomize_side();
      tick();
      k++;
    end while (!last_acc && k < 200);
    if (!last_acc) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
    mgmt_we  = 1'b0;
  endtask

  task automatic mwrite(input logic [1:0] s, input logic [12:0] a, input logic [15:0] d);
    mgmt_we = 1'b1; mgmt_sel = s; mgmt_addr = a; mgmt_wdata = d;
    tick();
    mgmt_we = 1'b0;
  endtask

  task automatic drain();
    int unsigned k = 0;
    in_valid = 1'b0; mgmt_we = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 40) begin tick(); k++; end
    check_eq("drain_empty", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic idle_check_drop(input string tag);
    in_valid = 1'b0; mgmt_we = 1'b0;
    repeat (3) tick();
    check_eq(tag, drop_cnt, drop_m);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, out0;
    for (int i = 0; i < 8192; i++) uc_m[i] = '0;
    for (int i = 0; i < 16; i++) begin l3_m[i] = '0; cs_m[i] = '0; end
    mask_m = 16'hFFFF; drop_m = 0;
    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_idx = '0; in_data = '0;
    out_ready = 1'b1; mgmt_we = 1'b0; mgmt_sel = '0; mgmt_addr = '0; mgmt_wdata = '0;

    // Reset
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_outputs", {out_uc, out_data, out_l3len, out_csum}, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Program tables
    for (int c = 0; c < 16; c++) begin
      mwrite(2'd1, 13'(c), {4{4'(c)}});
      mwrite(2'd2, 13'(c), {4'hF, 4'(c), 4'(c), 4'hF});
      for (int i = 0; i < 32; i++)
        mwrite(2'd0, {4'(c), 9'(i)}, {8'h00, 4'(c), 4'(i)});
    end

    // Full-rate stream
    lat_chk = 1'b1; tput_chk = 1'b1;
    for (int n = 0; n < 256; n++)
      send(4'(n), 9'($urandom_range(31)), 16'($urandom));
    tput_chk = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Random backpressure with interleaved management writes
    or_rand = 1'b1; mg_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        randomize_side();
        tick();
      end
      send(4'($urandom), 9'($urandom_range(31)), 16'($urandom));
    end
    or_rand = 1'b0; mg_rand = 1'b0;
    drain();

    // Full stall: output register plus two skid entries
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_chan  = 4'($urandom);
      in_idx   = 9'($urandom_range(31));
      in_data  = 16'($urandom);
      tick();
    end
    check_eq("stall_accepts", n_acc - acc0, 3);
    #1;
    check_eq("stall_rdy", in_ready, 0);
    drain();

    // Channel mask and drop counter
    mwrite(2'd3, 13'h0, 16'hFFFE);
    out0 = n_out;
    for (int n = 0; n < 10; n++) send(4'd0, 9'($urandom_range(31)), 16'($urandom));
    for (int n = 0; n < 5; n++)  send(4'd1, 9'($urandom_range(31)), 16'($urandom));
    drain();
    check_eq("mask_outputs", n_out - out0, 5);
    idle_check_drop("drop_cnt_10");
    check_eq("drop_model_10", drop_cnt, 10);
    send(4'd0, 9'd3, 16'h1234);
    mwrite(2'd3, 13'h0, 16'hFFFE);
    idle_check_drop("drop_clear_prio");

    // Saturation
    for (int n = 0; n < 1000; n++) send(4'd0, 9'd0, 16'($urandom));
    idle_check_drop("drop_cnt_1000");
    for (int n = 0; n < 69000; n++) send(4'd0, 9'd0, 16'($urandom));
    idle_check_drop("drop_cnt_sat");
    check_eq("drop_sat_value", drop_cnt, 16'hFFFF);

    // Reset mid-stream with beats pending; mask left at FFFE to see it restored
    drain();
    out_ready = 1'b0;
    send(4'd2, 9'd5, 16'hAAAA);
    out_ready = 1'b0;
    send(4'd3, 9'd6, 16'h5555);
    out_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_flush_valid", out_valid, 0);
    check_eq("rst_flush_drop", drop_cnt, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    lat_chk = 1'b1;
    for (int n = 0; n < 40; n++)
      send(4'(n), 9'($urandom_range(31)), 16'($urandom));
    drain();
    lat_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
